// File: rtl/ascon_ctrl_fsm.sv
// Ascon AEAD encryption control FSM: sequences init, AD, plaintext and finalization
// permutation runs, and drives the datapath enables from the state and the round counter.
module ascon_ctrl_fsm (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] nb_blocks_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
  output logic       input_select_o,
  output logic       ena_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       ena_reg_state_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [1:0] xor_down_sel_o,
  output logic       ena_cipher_o,
  output logic       ena_tag_o,
  output logic       data_req_o,
  output logic       data_ack_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned BLK_W = 4;
  localparam int unsigned RND_W = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(0);
  localparam logic [RND_W-1:0] RND_MID   = RND_W'(6);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(11);

  localparam logic [SEL_W-1:0] SEL_KEY_LO  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_DOMAIN  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_KEY_HI  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_KEY_DOM = SEL_W'(3);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CONF_INIT = 4'd1,
    INIT      = 4'd2,
    WAIT_AD   = 4'd3,
    CONF_AD   = 4'd4,
    AD        = 4'd5,
    WAIT_PT   = 4'd6,
    CONF_PT   = 4'd7,
    PT        = 4'd8,
    CONF_FIN  = 4'd9,
    FIN       = 4'd10,
    DONE      = 4'd11
  } state_e;

  state_e           state, state_n;
  logic [BLK_W-1:0] blocks_left, blocks_left_n;

  // State and block-count registers
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state       <= IDLE;
      blocks_left <= '0;
    end else begin
      state       <= state_n;
      blocks_left <= blocks_left_n;
    end
  end

  // Next state and combinational decode of state/round into datapath controls
  always_comb begin
    state_n         = state;
    blocks_left_n   = blocks_left;
    input_select_o  = 1'b0;
    ena_cpt_o       = 1'b0;
    init_a_o        = 1'b0;
    init_b_o        = 1'b0;
    ena_reg_state_o = 1'b0;
    ena_xor_up_o    = 1'b0;
    ena_xor_down_o  = 1'b0;
    xor_down_sel_o  = SEL_KEY_LO;
    ena_cipher_o    = 1'b0;
    ena_tag_o       = 1'b0;
    data_req_o      = 1'b0;
    data_ack_o      = 1'b0;
    busy_o          = (state != IDLE);
    done_o          = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_n       = CONF_INIT;
          blocks_left_n = (nb_blocks_i == '0) ? BLK_W'(1) : nb_blocks_i;
        end
      end
      CONF_INIT: begin
        ena_cpt_o = 1'b1;
        init_a_o  = 1'b1;
        state_n   = INIT;
      end
      INIT: begin
        ena_cpt_o       = 1'b1;
        ena_reg_state_o = 1'b1;
        // Round 0 loads the external key/nonce/IV state; later rounds iterate
        input_select_o  = (round_i != RND_FIRST);
        if (round_i == RND_LAST) begin
          ena_xor_down_o = 1'b1;
          xor_down_sel_o = SEL_KEY_LO;
          state_n        = WAIT_AD;
        end
      end
      WAIT_AD: begin
        data_req_o = 1'b1;
        if (data_valid_i) state_n = CONF_AD;
      end
      CONF_AD: begin
        ena_cpt_o = 1'b1;
        init_b_o  = 1'b1;
        state_n   = AD;
      end
      AD: begin
        ena_cpt_o       = 1'b1;
        ena_reg_state_o = 1'b1;
        input_select_o  = 1'b1;
        if (round_i == RND_MID) begin
          ena_xor_up_o = 1'b1;
          data_ack_o   = 1'b1;
        end
        if (round_i == RND_LAST) begin
          ena_xor_down_o = 1'b1;
          xor_down_sel_o = (blocks_left > BLK_W'(1)) ? SEL_DOMAIN : SEL_KEY_DOM;
          state_n        = WAIT_PT;
        end
      end
      WAIT_PT: begin
        data_req_o = 1'b1;
        if (data_valid_i) begin
          state_n = (blocks_left > BLK_W'(1)) ? CONF_PT : CONF_FIN;
        end
      end
      CONF_PT: begin
        ena_cpt_o = 1'b1;
        init_b_o  = 1'b1;
        state_n   = PT;
      end
      PT: begin
        ena_cpt_o       = 1'b1;
        ena_reg_state_o = 1'b1;
        input_select_o  = 1'b1;
        if (round_i == RND_MID) begin
          ena_xor_up_o = 1'b1;
          ena_cipher_o = 1'b1;
          data_ack_o   = 1'b1;
        end
        if (round_i == RND_LAST) begin
          // Last intermediate block pre-loads the key half used by finalization
          if (blocks_left == BLK_W'(2)) begin
            ena_xor_down_o = 1'b1;
            xor_down_sel_o = SEL_KEY_HI;
          end
          if (blocks_left > BLK_W'(1)) blocks_left_n = blocks_left - BLK_W'(1);
          state_n = WAIT_PT;
        end
      end
      CONF_FIN: begin
        ena_cpt_o = 1'b1;
        init_a_o  = 1'b1;
        state_n   = FIN;
      end
      FIN: begin
        ena_cpt_o       = 1'b1;
        ena_reg_state_o = 1'b1;
        input_select_o  = 1'b1;
        if (round_i == RND_FIRST) begin
          ena_xor_up_o = 1'b1;
          ena_cipher_o = 1'b1;
          data_ack_o   = 1'b1;
        end
        if (round_i == RND_LAST) begin
          ena_xor_down_o = 1'b1;
          xor_down_sel_o = SEL_KEY_LO;
          ena_tag_o      = 1'b1;
          state_n        = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Randomized self-checking bench for ascon_ctrl_fsm: a phase-schedule model predicts
// every output cycle by cycle, with a simple round-counter datapath model in the loop.
module tb_ascon_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nb = 4'd0;
  logic       dv = 1'b0;
  logic [3:0] round;

  logic       input_select, ena_cpt, init_a, init_b, ena_reg_state;
  logic       ena_xor_up, ena_xor_down, ena_cipher, ena_tag;
  logic       data_req, data_ack, busy, done;
  logic [1:0] xor_down_sel;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;

  ascon_ctrl_fsm dut (
    .clock_i        (clk),
    .resetb_i       (rst_n),
    .start_i        (start),
    .nb_blocks_i    (nb),
    .data_valid_i   (dv),
    .round_i        (round),
    .input_select_o (input_select),
    .ena_cpt_o      (ena_cpt),
    .init_a_o       (init_a),
    .init_b_o       (init_b),
    .ena_reg_state_o(ena_reg_state),
    .ena_xor_up_o   (ena_xor_up),
    .ena_xor_down_o (ena_xor_down),
    .xor_down_sel_o (xor_down_sel),
    .ena_cipher_o   (ena_cipher),
    .ena_tag_o      (ena_tag),
    .data_req_o     (data_req),
    .data_ack_o     (data_ack),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  // Datapath round counter driven by the FSM's counter controls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       round <= 4'd0;
    else if (init_a)  round <= 4'd0;
    else if (init_b)  round <= 4'd6;
    else if (ena_cpt) round <= round + 4'd1;
  end

  assign obs = {input_select, ena_cpt, init_a, init_b, ena_reg_state, ena_xor_up,
                ena_xor_down, xor_down_sel, ena_cipher, ena_tag, data_req, data_ack,
                busy, done};

  typedef enum int {K_CONF_A, K_INIT, K_WAIT, K_CONF_B, K_AD, K_PT, K_FIN, K_DONE} kind_e;
  typedef struct {
    kind_e kind;
    bit    last;
  } seg_t;

  seg_t segs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int seg_len(kind_e k);
    case (k)
      K_INIT, K_FIN: return 12;
      K_AD, K_PT:    return 6;
      default:       return 1;
    endcase
  endfunction

  // Expected output vector for a phase at a given round
  function automatic logic [14:0] expect_out(kind_e k, int r, bit last, int nbe);
    logic insel, cpt, ia, ib, rs, xu, xd, ci, tg, rq, ak, bz, dn;
    logic [1:0] sel;
    {insel, cpt, ia, ib, rs, xu, xd, ci, tg, rq, ak, dn} = '0;
    sel = 2'b00;
    bz  = 1'b1;
    case (k)
      K_CONF_A: begin cpt = 1; ia = 1; end
      K_CONF_B: begin cpt = 1; ib = 1; end
      K_WAIT:   rq = 1;
      K_DONE:   dn = 1;
      K_INIT: begin
        cpt = 1; rs = 1; insel = (r != 0);
        if (r == 11) xd = 1;
      end
      K_AD: begin
        cpt = 1; rs = 1; insel = 1;
        if (r == 6) begin xu = 1; ak = 1; end
        if (r == 11) begin xd = 1; sel = (nbe > 1) ? 2'b01 : 2'b11; end
      end
      K_PT: begin
        cpt = 1; rs = 1; insel = 1;
        if (r == 6) begin xu = 1; ci = 1; ak = 1; end
        if (r == 11 && last) begin xd = 1; sel = 2'b10; end
      end
      K_FIN: begin
        cpt = 1; rs = 1; insel = 1;
        if (r == 0) begin xu = 1; ci = 1; ak = 1; end
        if (r == 11) begin xd = 1; tg = 1; end
      end
      default: bz = 1;
    endcase
    return {insel, cpt, ia, ib, rs, xu, xd, sel, ci, tg, rq, ak, bz, dn};
  endfunction

  task automatic run(input int nb_in, input int stall_pct, input bit from_reset,
                     input bit rst_fin4);
    int    nbe;
    int    cyc;
    int    stalls;
    int    off;
    int    r;
    seg_t  s;
    nbe = (nb_in == 0) ? 1 : nb_in;
    segs.delete();
    segs.push_back('{K_CONF_A, 1'b0});
    segs.push_back('{K_INIT, 1'b0});
    segs.push_back('{K_WAIT, 1'b0});
    segs.push_back('{K_CONF_B, 1'b0});
    segs.push_back('{K_AD, 1'b0});
    for (int j = 1; j < nbe; j++) begin
      segs.push_back('{K_WAIT, 1'b0});
      segs.push_back('{K_CONF_B, 1'b0});
      segs.push_back('{K_PT, j == nbe - 1});
    end
    segs.push_back('{K_WAIT, 1'b0});
    segs.push_back('{K_CONF_A, 1'b0});
    segs.push_back('{K_FIN, 1'b0});
    segs.push_back('{K_DONE, 1'b0});

    if (from_reset) begin
      start = 1'b1;
      nb    = 4'(nb_in);
      rst_n = 1'b1;
    end else begin
      @(posedge clk); #1;
      start = 1'b1;
      nb    = 4'(nb_in);
      dv    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_start", 32'(obs), 32'(expect_out(K_DONE, 0, 1'b0, nbe) & 15'h0));
    end

    cyc = 0; stalls = 0; off = 0;
    while (segs.size() > 0) begin
      @(posedge clk); #1;
      cyc++;
      s     = segs[0];
      start = ($urandom_range(0, 15) == 0);
      nb    = 4'($urandom);
      if (s.kind == K_WAIT) dv = ($urandom_range(0, 99) >= stall_pct);
      else                  dv = 1'($urandom_range(0, 1));
      @(negedge clk);
      r = (s.kind == K_AD || s.kind == K_PT) ? 6 + off : off;
      check($sformatf("%s nb=%0d c%0d", s.kind.name(), nb_in, cyc), 32'(obs),
            32'(expect_out(s.kind, r, s.last, nbe)));
      if (s.kind == K_INIT || s.kind == K_AD || s.kind == K_PT || s.kind == K_FIN)
        check($sformatf("round c%0d", cyc), 32'(round), 32'(r));
      if (s.kind == K_DONE)
        check($sformatf("latency nb=%0d", nb_in), 32'(cyc), 32'(36 + 8 * (nbe - 1) + stalls));
      if (rst_fin4 && s.kind == K_FIN && off == 4) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_async", 32'(obs), 32'h0);
        #1;
        rst_n = 1'b1;
        segs.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs), 32'h0);
        return;
      end
      if (s.kind == K_WAIT) begin
        if (dv) void'(segs.pop_front());
        else    stalls++;
      end else begin
        off++;
        if (off == seg_len(s.kind)) begin
          off = 0;
          void'(segs.pop_front());
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    dv    = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_after_done", 32'(obs), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    nb    = 4'd1;
    dv    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(obs), 32'h0);
    run(1, 0, 1'b1, 1'b0);
    run(1, 0, 1'b0, 1'b0);
    run(3, 0, 1'b0, 1'b0);
    run(0, 0, 1'b0, 1'b0);
    run(2, 50, 1'b0, 1'b0);
    run(3, 30, 1'b0, 1'b1);
    run(2, 0, 1'b0, 1'b0);
    run(15, 20, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 60)), 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl_fsm.md
ASCON_CTRL_FSM -- requirements
Module: ascon_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide these ports, clock and reset first:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous reset, active low.
- start_i  in  1  start one encryption; sampled only in IDLE.
- nb_blocks_i  in  4  plaintext block count, sampled on start; 0 is treated as 1.
- data_valid_i  in  1  current AD/plaintext block present on the datapath XOR-up input.
- round_i  in  4  round counter value from the datapath.
- input_select_o  out  1  0 = datapath loads external initial state; 1 = feedback.
- ena_cpt_o  out  1  round counter enable.
- init_a_o  out  1  load counter with 0 (12-round run).
- init_b_o  out  1  load counter with 6 (6-round run).
- ena_reg_state_o  out  1  state register enable.
- ena_xor_up_o  out  1  XOR 64-bit data into S0 at permutation input.
- ena_xor_down_o  out  1  XOR 256-bit word into S1..S4 at permutation output.
- xor_down_sel_o  out  2  top-level mux select for the XOR-down word:
  - 00 = key into S3,S4.
  - 01 = domain-separation bit only.
  - 10 = key into S1,S2.
  - 11 = key into S1,S2 plus domain-separation bit.
- ena_cipher_o  out  1  cipher register capture.
- ena_tag_o  out  1  tag register capture.
- data_req_o  out  1  FSM waiting for a block.
- data_ack_o  out  1  block consumed this cycle; the top holds data until this pulse.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CONF_INIT, INIT, WAIT_AD, CONF_AD, AD, WAIT_PT, CONF_PT, PT, CONF_FIN, FIN, DONE.
REQ-004 Outputs SHALL be combinational from state and round_i; every output not listed for a state SHALL be 0.
REQ-005 CONF_* states SHALL assert ena_cpt_o=1 and ena_reg_state_o=0, plus init_a_o (CONF_INIT, CONF_FIN) or init_b_o (CONF_AD, CONF_PT).
REQ-006 INIT, AD, PT and FIN SHALL assert ena_cpt_o=1 and ena_reg_state_o=1, with input_select_o=1 except in INIT when round_i=0.
REQ-007 State transitions SHALL be:
- IDLE -> CONF_INIT on start_i, loading blocks_left from nb_blocks_i.
- CONF_INIT -> INIT.
- INIT -> WAIT_AD when round_i=11.
- WAIT_AD -> CONF_AD on data_valid_i.
- CONF_AD -> AD.
- AD -> WAIT_PT when round_i=11.
- WAIT_PT -> CONF_FIN when data_valid_i and blocks_left=1.
- WAIT_PT -> CONF_PT when data_valid_i and blocks_left>1.
- CONF_PT -> PT.
- PT -> WAIT_PT when round_i=11, decrementing blocks_left.
- CONF_FIN -> FIN.
- FIN -> DONE when round_i=11.
- DONE -> IDLE.
REQ-008 data_req_o SHALL equal 1 exactly in WAIT_AD and WAIT_PT.
REQ-009 XOR-up and capture events SHALL be:
- AD, round 6: ena_xor_up_o and data_ack_o.
- PT, round 6, and FIN, round 0: ena_xor_up_o, ena_cipher_o and data_ack_o.
REQ-010 Round-11 XOR-down events SHALL be:
- INIT: ena_xor_down_o with sel 00.
- AD: sel 01 if blocks_left>1, else sel 11.
- PT: sel 10 only if blocks_left=2, else no XOR-down.
- FIN: sel 00 together with ena_tag_o.
REQ-011 done_o SHALL equal 1 only in DONE.
REQ-012 start_i outside IDLE and data_valid_i outside WAIT states SHALL be ignored.
REQ-013 Latency SHALL be:
- With data_valid_i held high and nb=1: 36 cycles from the start_i edge to the done_o cycle inclusive.
- Each extra block: +8 cycles.
- Each WAIT cycle without data_valid_i: +1 cycle.
REQ-014 The blocks_left counter SHALL be 4 bits wide and SHALL never wrap below 1.

Reset
REQ-015 resetb_i=0 SHALL force IDLE and blocks_left=0 immediately, clear every output to 0, and abandon any run in progress.
REQ-016 The first start_i after reset release SHALL begin a complete fresh run.

Verification
REQ-017 Reset held, start_i=1 -> all outputs 0; after release, CONF_INIT is entered on the next edge.
REQ-018 nb_blocks_i=1, data_valid_i=1, datapath counter model -> sequence:
- 1 init_a cycle, then 12 INIT rounds with input_select_o=0 only at round 0 and XOR-down sel 00 at round 11.
- AD: XOR-down sel 11 at round 11.
- FIN: ena_cipher_o at round 0, ena_tag_o at round 11.
- done_o in cycle 36.
REQ-019 nb_blocks_i=3 -> 2 PT runs (init_b, rounds 6..11):
- XOR-down sel 10 only at the end of the second PT run.
- AD sel 01.
- done_o in cycle 52.
REQ-020 data_valid_i low 5 cycles in WAIT_PT -> data_req_o high 5 extra cycles, no counter or state enables, done_o delayed by 5.
REQ-021 resetb_i pulsed low during FIN round 4 -> outputs 0 at once, IDLE; a subsequent start runs a full sequence.
REQ-022 nb_blocks_i=0 -> identical to nb=1; start_i pulsed mid-run -> ignored.
